// File: rtl/stream_tap_buffer.sv
// rtl/stream_tap_buffer.sv - beat-counted multi-tap stream delay line; option STREAM_TAP_BUFFER_PRIME_EN
module stream_tap_buffer #(
    parameter int STREAMW   = 32,
    parameter int NTAPS     = 3,
    parameter int TAPSTRIDE = 1,
    localparam int SIZE     = (NTAPS - 1) * TAPSTRIDE + 1,
    localparam int FILLW    = $clog2(SIZE + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STREAMW-1:0]         in1_s0,
    input  logic                       ivalid_in1_s0,
    output logic                       iready,
    input  logic                       oready,
    output logic                       ovalid,
    output logic [NTAPS*STREAMW-1:0]   out_taps,
    output logic [FILLW-1:0]           fill_level
);

    localparam logic [FILLW-1:0] FILL_MAX = FILLW'(SIZE);

    logic [STREAMW-1:0] entry [SIZE];
    logic               accept;
    logic               out_fire;
    logic               window_ready;

    assign iready   = rst & (~ovalid | oready);
    assign accept   = ivalid_in1_s0 & iready;
    assign out_fire = ovalid & oready;

`ifdef STREAM_TAP_BUFFER_PRIME_EN
    // The accepting beat itself completes the window, hence SIZE-1 already held.
    assign window_ready = (fill_level >= FILLW'(SIZE - 1));
`else
    assign window_ready = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SIZE; i++) begin
                entry[i] <= '0;
            end
        end else if (accept) begin
            entry[0] <= in1_s0;
            for (int i = 1; i < SIZE; i++) begin
                entry[i] <= entry[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_level <= '0;
        end else if (accept && (fill_level != FILL_MAX)) begin
            fill_level <= fill_level + FILLW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovalid <= 1'b0;
        end else if (accept && window_ready) begin
            ovalid <= 1'b1;
        end else if (out_fire) begin
            ovalid <= 1'b0;
        end
    end

    // Taps read the shift register directly; it only moves on accept.
    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        assign out_taps[k*STREAMW +: STREAMW] = entry[k*TAPSTRIDE];
    end

endmodule

// File: tb/tb_stream_tap_buffer.sv
// tb/tb_stream_tap_buffer.sv - scoreboard bench for stream_tap_buffer
module tb_stream_tap_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        ivalid;
    logic        iready;
    logic        oready;
    logic        ovalid;
    logic [23:0] taps;
    logic [2:0]  fill;

    logic [7:0]  din1;
    logic        ivalid1;
    logic        iready1;
    logic        oready1;
    logic        ovalid1;
    logic [7:0]  taps1;
    logic [0:0]  fill1;

    int vectors    = 0;
    int miscompares = 0;
    int delivered1 = 0;

    logic [23:0] q  [$];
    logic [7:0]  q1 [$];

    logic [7:0]  seq_a [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    logic [23:0] exp_a [6] = '{24'h000001, 24'h000002, 24'h000103,
                               24'h000204, 24'h010305, 24'h020406};
    logic [7:0]  seq_b [6] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd0};
    logic [23:0] exp_b [6] = '{24'h00000a, 24'h00000b, 24'h000a0c,
                               24'h000b0d, 24'h0a0c0e, 24'h000000};

    always #5 clk = ~clk;

    stream_tap_buffer #(.STREAMW(8), .NTAPS(3), .TAPSTRIDE(2)) u_dut (
        .clk(clk), .rst(rst), .in1_s0(din), .ivalid_in1_s0(ivalid),
        .iready(iready), .oready(oready), .ovalid(ovalid),
        .out_taps(taps), .fill_level(fill)
    );

    stream_tap_buffer #(.STREAMW(8), .NTAPS(1), .TAPSTRIDE(1)) u_one (
        .clk(clk), .rst(rst), .in1_s0(din1), .ivalid_in1_s0(ivalid1),
        .iready(iready1), .oready(oready1), .ovalid(ovalid1),
        .out_taps(taps1), .fill_level(fill1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ovalid && oready) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_window: got %06h expected none", taps);
            end else begin
                chk("window", {8'h0, taps}, {8'h0, q.pop_front()});
            end
        end
        if (ovalid1 && oready1) begin
            delivered1++;
            if (q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat_ntaps1: got %02h expected none", taps1);
            end else begin
                chk("beat_ntaps1", {24'h0, taps1}, {24'h0, q1.pop_front()});
            end
        end
    end

    function automatic bit emits(input int i);
`ifdef STREAM_TAP_BUFFER_PRIME_EN
        return i >= 4;
`else
        return i >= 0;
`endif
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d);
        bit acc = 1'b0;
        int n = 0;
        ivalid = 1'b1;
        din = d;
        do begin
            @(negedge clk);
            acc = iready;
            n++;
            @(posedge clk);
            #1;
        end while (!acc && n < 50);
        ivalid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ivalid = 1'b0;
        oready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_iready", {31'h0, iready}, 32'd0);
        chk("rst_ovalid", {31'h0, ovalid}, 32'd0);
        chk("rst_fill", {29'h0, fill}, 32'd0);
        chk("rst_taps", {8'h0, taps}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run_seq(input logic [7:0] vals [6], input logic [23:0] exps [6],
                           input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (emits(i)) q.push_back(exps[i]);
            send(vals[i]);
            if (i == 0) chk("fill_after_first", {29'h0, fill}, 32'd1);
            idle(gap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int next;
        int cyc;
        bit acc;
        rst = 1'b0; din = '0; ivalid = 1'b0; oready = 1'b1;
        din1 = '0; ivalid1 = 1'b0; oready1 = 1'b1;

        // back to back
        do_reset();
        run_seq(seq_a, exp_a, 6, 0);
        idle(3);
        chk("b2b_fill", {29'h0, fill}, 32'd5);
        chk("b2b_drained", q.size(), 32'd0);

        // backpressure
        do_reset();
        run_seq(seq_a, exp_a, 5, 0);
        oready = 1'b0;
        ivalid = 1'b1;
        din = 8'd6;
        repeat (4) begin
            @(negedge clk);
            chk("stall_iready", {31'h0, iready}, 32'd0);
            chk("stall_ovalid", {31'h0, ovalid}, 32'd1);
            chk("stall_taps", {8'h0, taps}, 32'h010305);
            @(posedge clk);
            #1;
        end
        q.push_back(24'h020406);
        oready = 1'b1;
        send(8'd6);
        chk("bp_fill", {29'h0, fill}, 32'd5);
        idle(3);
        chk("bp_drained", q.size(), 32'd0);

        // bubbles
        do_reset();
        run_seq(seq_a, exp_a, 6, 3);
        idle(3);
        chk("bubble_drained", q.size(), 32'd0);

        // reset mid-stream
        do_reset();
        run_seq(seq_a, exp_a, 3, 0);
        rst = 1'b0;
        ivalid = 1'b1;
        din = 8'd9;
        @(negedge clk);
        chk("midrst_iready", {31'h0, iready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ivalid = 1'b0;
        chk("midrst_fill", {29'h0, fill}, 32'd0);
        chk("midrst_ovalid", {31'h0, ovalid}, 32'd0);
        run_seq(seq_b, exp_b, 5, 0);
        idle(3);
        chk("midrst_fill_end", {29'h0, fill}, 32'd5);
        chk("midrst_drained", q.size(), 32'd0);

        // NTAPS=1 with toggling oready
        next = 1;
        cyc = 0;
        din1 = 8'(next);
        q1.push_back(8'(next));
        ivalid1 = 1'b1;
        while (ivalid1 && cyc < 200) begin
            @(negedge clk);
            acc = iready1 && ivalid1;
            @(posedge clk);
            #1;
            cyc++;
            oready1 = ~oready1;
            if (acc) begin
                if (next == 12) begin
                    ivalid1 = 1'b0;
                end else begin
                    next++;
                    din1 = 8'(next);
                    q1.push_back(8'(next));
                end
            end
        end
        chk("ntaps1_all_sent", {31'h0, ivalid1}, 32'd0);
        oready1 = 1'b1;
        idle(4);
        chk("ntaps1_count", delivered1, 32'd12);
        chk("ntaps1_drained", q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
